// File: rtl/mem_ctrl_pkg.sv
// ============================================================================
// Module : mem_ctrl_pkg
// Brief  : Shared types and default widths for the memory access controller.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package mem_ctrl_pkg;

  localparam int DEF_ADDR_W = 16;
  localparam int DEF_DATA_W = 16;
  localparam int WAIT_W     = 4;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ADDR = 3'd1,
    ST_WAIT = 3'd2,
    ST_XFER = 3'd3,
    ST_DONE = 3'd4
  } state_t;

  typedef enum logic {
    REQ_IF = 1'b0,
    REQ_DM = 1'b1
  } req_id_t;

endpackage

`default_nettype wire

// File: rtl/mem_ctrl_arbiter.sv
// ============================================================================
// Module : mem_ctrl_arbiter
// Brief  : Two-requester arbiter, one-hot winner. MEMCTRL_ROUND_ROBIN_EN
//          selects round-robin tie-break; otherwise data wins every tie.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module mem_ctrl_arbiter
  import mem_ctrl_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic i_upd,
  input  logic i_if_req,
  input  logic i_dm_req,
  output logic o_win_if,
  output logic o_win_dm
);

  logic w_win_if;
  logic w_win_dm;

`ifdef MEMCTRL_ROUND_ROBIN_EN
  req_id_t r_last;

  // On a tie, fetch wins only if data was the last one served.
  assign w_win_dm = i_dm_req && !(i_if_req && (r_last == REQ_DM));
  assign w_win_if = i_if_req && !w_win_dm;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_last <= REQ_IF;
    end else if (i_upd && (w_win_if || w_win_dm)) begin
      r_last <= w_win_dm ? REQ_DM : REQ_IF;
    end
  end
`else
  logic w_unused;

  assign w_win_dm = i_dm_req;
  assign w_win_if = i_if_req && !i_dm_req;
  assign w_unused = ^{clk, reset, i_upd};
`endif

  assign o_win_if = w_win_if;
  assign o_win_dm = w_win_dm;

endmodule

`default_nettype wire

// File: rtl/mem_access_ctrl.sv
// ============================================================================
// Module : mem_access_ctrl
// Brief  : MAR/MDR access sequencer shared by instruction fetch and data
//          ports. Tie-break selected by MEMCTRL_ROUND_ROBIN_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module mem_access_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int WAIT_CYCLES = 1,
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int DATA_W      = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_if_req,
  input  logic [ADDR_W-1:0] i_if_addr,
  input  logic              i_dm_req,
  input  logic              i_dm_we,
  input  logic [ADDR_W-1:0] i_dm_addr,
  input  logic [DATA_W-1:0] i_dm_wdata,
  output logic              o_if_gnt,
  output logic              o_dm_gnt,
  output logic              o_if_done,
  output logic              o_dm_done,
  output logic              o_mar_write,
  output logic [ADDR_W-1:0] o_mar_addr,
  output logic              o_mdr_write,
  output logic              o_mem_we,
  output logic [DATA_W-1:0] o_mem_wdata,
  output logic              o_busy
);

  // WAIT exits when the counter reads zero, so it is loaded one short.
  localparam logic [WAIT_W-1:0] c_WAIT_LOAD =
    (WAIT_CYCLES > 0) ? WAIT_W'(WAIT_CYCLES - 1) : '0;
  localparam logic [WAIT_W-1:0] c_ONE = WAIT_W'(1);

  state_t              r_state;
  state_t              w_next;
  req_id_t             r_id;
  logic                r_we;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic [WAIT_W-1:0]   r_wait_cnt;
  logic                w_start;
  logic                w_win_if;
  logic                w_win_dm;

  assign w_start = (r_state == ST_IDLE) && (i_if_req || i_dm_req);

  mem_ctrl_arbiter u_arb (
    .clk      (clk),
    .reset    (reset),
    .i_upd    (w_start),
    .i_if_req (i_if_req),
    .i_dm_req (i_dm_req),
    .o_win_if (w_win_if),
    .o_win_dm (w_win_dm)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (w_start) w_next = ST_ADDR;
      ST_ADDR: w_next = (WAIT_CYCLES > 0) ? ST_WAIT : ST_XFER;
      ST_WAIT: if (r_wait_cnt == '0) w_next = ST_XFER;
      ST_XFER: w_next = ST_DONE;
      ST_DONE: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  // Operands are captured only at the start, so later changes cannot alter the access.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_id       <= REQ_IF;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_wait_cnt <= '0;
    end else begin
      if (w_start) begin
        r_id    <= w_win_dm ? REQ_DM : REQ_IF;
        r_we    <= w_win_dm && i_dm_we;
        r_addr  <= w_win_dm ? i_dm_addr : i_if_addr;
        r_wdata <= w_win_dm ? i_dm_wdata : '0;
      end
      if (r_state == ST_ADDR) begin
        r_wait_cnt <= c_WAIT_LOAD;
      end else if ((r_state == ST_WAIT) && (r_wait_cnt != '0)) begin
        r_wait_cnt <= r_wait_cnt - c_ONE;
      end
    end
  end

  always_comb begin
    o_if_gnt    = 1'b0;
    o_dm_gnt    = 1'b0;
    o_if_done   = 1'b0;
    o_dm_done   = 1'b0;
    o_mar_write = 1'b0;
    o_mdr_write = 1'b0;
    o_mem_we    = 1'b0;
    o_busy      = (r_state != ST_IDLE);
    case (r_state)
      ST_ADDR: begin
        o_mar_write = 1'b1;
        o_if_gnt    = (r_id == REQ_IF);
        o_dm_gnt    = (r_id == REQ_DM);
      end
      ST_XFER: begin
        o_mem_we    = r_we;
        o_mdr_write = !r_we;
      end
      ST_DONE: begin
        o_if_done   = (r_id == REQ_IF);
        o_dm_done   = (r_id == REQ_DM);
      end
      default: ;
    endcase
  end

  assign o_mar_addr  = r_addr;
  assign o_mem_wdata = r_wdata;

endmodule

`default_nettype wire

// File: tb/tb_mem_access_ctrl.sv
// ============================================================================
// Module : tb_mem_access_ctrl
// Brief  : Scoreboard bench for mem_access_ctrl, WAIT_CYCLES=1 and =0 instances.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_mem_access_ctrl;

  localparam int W1 = 1;
  localparam int W0 = 0;
  localparam int K_GNT_IF  = 0;
  localparam int K_GNT_DM  = 1;
  localparam int K_MAR     = 2;
  localparam int K_MDR     = 3;
  localparam int K_MEMWE   = 4;
  localparam int K_DONE_IF = 5;
  localparam int K_DONE_DM = 6;

  typedef struct {
    int          kind;
    logic [15:0] val;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        if_req [2];
  logic        dm_req [2];
  logic        dm_we [2];
  logic [15:0] if_addr [2];
  logic [15:0] dm_addr [2];
  logic [15:0] dm_wdata [2];
  logic        if_gnt [2];
  logic        dm_gnt [2];
  logic        if_done [2];
  logic        dm_done [2];
  logic        mar_write [2];
  logic        mdr_write [2];
  logic        mem_we [2];
  logic        busy [2];
  logic [15:0] mar_addr [2];
  logic [15:0] mem_wdata [2];

  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;
  exp_t q0[$];
  exp_t q1[$];
  bit   m_last [2];   // 1 = data served last

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mem_access_ctrl #(.WAIT_CYCLES(W0), .ADDR_W(16), .DATA_W(16)) u_dut_w0 (
    .clk(clk), .reset(reset),
    .i_if_req(if_req[0]), .i_if_addr(if_addr[0]),
    .i_dm_req(dm_req[0]), .i_dm_we(dm_we[0]), .i_dm_addr(dm_addr[0]), .i_dm_wdata(dm_wdata[0]),
    .o_if_gnt(if_gnt[0]), .o_dm_gnt(dm_gnt[0]), .o_if_done(if_done[0]), .o_dm_done(dm_done[0]),
    .o_mar_write(mar_write[0]), .o_mar_addr(mar_addr[0]), .o_mdr_write(mdr_write[0]),
    .o_mem_we(mem_we[0]), .o_mem_wdata(mem_wdata[0]), .o_busy(busy[0])
  );

  mem_access_ctrl #(.WAIT_CYCLES(W1), .ADDR_W(16), .DATA_W(16)) u_dut_w1 (
    .clk(clk), .reset(reset),
    .i_if_req(if_req[1]), .i_if_addr(if_addr[1]),
    .i_dm_req(dm_req[1]), .i_dm_we(dm_we[1]), .i_dm_addr(dm_addr[1]), .i_dm_wdata(dm_wdata[1]),
    .o_if_gnt(if_gnt[1]), .o_dm_gnt(dm_gnt[1]), .o_if_done(if_done[1]), .o_dm_done(dm_done[1]),
    .o_mar_write(mar_write[1]), .o_mar_addr(mar_addr[1]), .o_mdr_write(mdr_write[1]),
    .o_mem_we(mem_we[1]), .o_mem_wdata(mem_wdata[1]), .o_busy(busy[1])
  );

  function automatic int wcyc(input int d);
    return (d == 1) ? W1 : W0;
  endfunction

  function automatic bit tie_winner_dm(input int d);
`ifdef MEMCTRL_ROUND_ROBIN_EN
    return !m_last[d];
`else
    return 1'b1;
`endif
  endfunction

  function automatic logic [63:0] outs(input int d);
    return 64'({if_gnt[d], dm_gnt[d], if_done[d], dm_done[d], mar_write[d],
                mdr_write[d], mem_we[d], busy[d], mar_addr[d], mem_wdata[d]});
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input int d, input int kind, input logic [15:0] val, input int c);
    exp_t e;
    e.kind = kind;
    e.val  = val;
    e.cyc  = c;
    if (d == 0) q0.push_back(e);
    else        q1.push_back(e);
  endtask

  // Expected strobe pattern of one access whose request is sampled at edge s-1.
  task automatic push_access(input int d, input bit is_dm, input logic [15:0] addr,
                             input bit we, input logic [15:0] wd, input int s);
    int w;
    w = wcyc(d);
    push(d, is_dm ? K_GNT_DM : K_GNT_IF, 16'h0, s);
    push(d, K_MAR, addr, s);
    if (is_dm && we) push(d, K_MEMWE, wd, s + w + 1);
    else             push(d, K_MDR, 16'h0, s + w + 1);
    push(d, is_dm ? K_DONE_DM : K_DONE_IF, 16'h0, s + w + 2);
    m_last[d] = is_dm;
  endtask

  task automatic mon_evt(input int d, input int kind, input logic [15:0] val);
    exp_t e;
    n_cmp++;
    if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
      n_err++;
      $display("FAIL unexpected_event dut%0d: got kind %0d val %h at cycle %0d, expected none",
               d, kind, val, cyc);
      return;
    end
    if (d == 0) e = q0.pop_front();
    else        e = q1.pop_front();
    if (e.kind != kind || e.val !== val || e.cyc != cyc) begin
      n_err++;
      $display("FAIL event dut%0d: got kind %0d val %h cycle %0d, expected kind %0d val %h cycle %0d",
               d, kind, val, cyc, e.kind, e.val, e.cyc);
    end
  endtask

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (if_gnt[d])    mon_evt(d, K_GNT_IF, 16'h0);
      if (dm_gnt[d])    mon_evt(d, K_GNT_DM, 16'h0);
      if (mar_write[d]) mon_evt(d, K_MAR, mar_addr[d]);
      if (mdr_write[d]) mon_evt(d, K_MDR, 16'h0);
      if (mem_we[d])    mon_evt(d, K_MEMWE, mem_wdata[d]);
      if (if_done[d])   mon_evt(d, K_DONE_IF, 16'h0);
      if (dm_done[d])   mon_evt(d, K_DONE_DM, 16'h0);
    end
  end

  task automatic wait_to(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic issue(input int d, input bit is_dm, input logic [15:0] addr, input bit we,
                       input logic [15:0] wd, input bit change_ops);
    int s;
    int w;
    w = wcyc(d);
    if (is_dm) begin
      dm_req[d] = 1'b1; dm_we[d] = we; dm_addr[d] = addr; dm_wdata[d] = wd;
    end else begin
      if_req[d] = 1'b1; if_addr[d] = addr;
    end
    s = cyc + 1;
    push_access(d, is_dm, addr, we, wd, s);
    wait_to(s);
    check("busy_in_addr", 64'(busy[d]), 64'd1);
    if (change_ops) begin
      dm_addr[d] = ~addr; dm_wdata[d] = ~wd; if_addr[d] = ~addr;
    end
    wait_to(s + w + 1);
    check("mar_addr_held", 64'(mar_addr[d]), 64'(addr));
    check("mem_wdata_held", 64'(mem_wdata[d]), is_dm ? 64'(wd) : 64'd0);
    wait_to(s + w + 2);
    if_req[d] = 1'b0; dm_req[d] = 1'b0; dm_we[d] = 1'b0;
    wait_to(s + w + 3);
    check("busy_low_after_done", 64'(busy[d]), 64'd0);
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout at cycle %0d, expected completion", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int s;
    int w;
    for (int d = 0; d < 2; d++) begin
      if_req[d] = 1'b0; dm_req[d] = 1'b0; dm_we[d] = 1'b0;
      if_addr[d] = '0; dm_addr[d] = '0; dm_wdata[d] = '0;
      m_last[d] = 1'b0;
    end
    @(negedge clk);
    check("reset_outs_w0", outs(0), 64'd0);
    check("reset_outs_w1", outs(1), 64'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("post_reset_outs_w0", outs(0), 64'd0);
    check("post_reset_outs_w1", outs(1), 64'd0);

    // Both requesters held high for four back-to-back accesses.
    w = wcyc(1);
    if_req[1] = 1'b1; if_addr[1] = 16'h0100;
    dm_req[1] = 1'b1; dm_we[1] = 1'b0; dm_addr[1] = 16'h2000;
    s = cyc + 1;
    for (int k = 0; k < 4; k++) begin
      bit win_dm;
      win_dm = tie_winner_dm(1);
      push_access(1, win_dm, win_dm ? 16'h2000 : 16'h0100, 1'b0, 16'h0, s + k * (w + 4));
    end
    wait_to(s + 3 * (w + 4) + w + 2);
    if_req[1] = 1'b0; dm_req[1] = 1'b0;
    wait_to(s + 3 * (w + 4) + w + 3);
    check("busy_low_after_tie", 64'(busy[1]), 64'd0);

    issue(1, 1'b0, 16'h0040, 1'b0, 16'h0000, 1'b0);
    issue(1, 1'b1, 16'h1234, 1'b1, 16'hBEEF, 1'b1);
    issue(1, 1'b1, 16'h0ABC, 1'b0, 16'h0000, 1'b0);

    // Reset during WAIT of a data read: no transfer, no done.
    dm_req[1] = 1'b1; dm_we[1] = 1'b0; dm_addr[1] = 16'h0ABC; dm_wdata[1] = 16'h5555;
    s = cyc + 1;
    push(1, K_GNT_DM, 16'h0, s);
    push(1, K_MAR, 16'h0ABC, s);
    wait_to(s + 1);
    check("busy_in_wait", 64'(busy[1]), 64'd1);
    reset = 1'b1;
    dm_req[1] = 1'b0;
    wait_to(s + 2);
    check("reset_mid_access_outs", outs(1), 64'd0);
    wait_to(s + 3);
    check("reset_held_outs", outs(1), 64'd0);
    reset = 1'b0;
    m_last[0] = 1'b0; m_last[1] = 1'b0;
    wait_to(s + 4);
    check("after_mid_reset_outs", outs(1), 64'd0);
    issue(1, 1'b1, 16'h0777, 1'b0, 16'h0000, 1'b0);
    issue(1, 1'b0, 16'h00F0, 1'b0, 16'h0000, 1'b1);

    // Zero wait states.
    issue(0, 1'b1, 16'h0300, 1'b0, 16'h0000, 1'b1);
    issue(0, 1'b1, 16'h0400, 1'b1, 16'h1357, 1'b1);
    issue(0, 1'b0, 16'h0010, 1'b0, 16'h0000, 1'b0);

    repeat (4) @(negedge clk);
    check("scoreboard_empty_w0", 64'(q0.size()), 64'd0);
    check("scoreboard_empty_w1", 64'(q1.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
